// File: rtl/debug_pkg.sv
// Shared command bytes, controller state type and index sizing for the
// debug controller.
package debug_pkg;

  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_HALT = 8'h68;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_LATCH,
    ST_SEND,
    ST_WAIT
  } state_t;

  // Width of a byte index covering n_bytes entries, never narrower than 1.
  function automatic int unsigned idx_width(input int unsigned n_bytes);
    int unsigned w;
    w = $clog2(n_bytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debug_byte_sel.sv
// Picks byte[idx] out of the snapshot; each word is emitted whole before the
// next, with byte order within the word set by LSB_FIRST.
module debug_byte_sel
  import debug_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned IDX_W     = idx_width(NUM_WORDS * 4)
) (
  input  logic [NUM_WORDS*32-1:0] words,
  input  logic [IDX_W-1:0]        idx,
  output logic [7:0]              sel
);

  localparam int unsigned NB = NUM_WORDS * 4;

  logic [7:0] lanes [NB];

  for (genvar b = 0; b < NB; b++) begin : g_byte
    localparam int unsigned LANE = b % 4;
    localparam int unsigned OFF  = (b / 4) * 32 +
                                   ((LSB_FIRST != 0) ? LANE * 8 : 24 - LANE * 8);
    assign lanes[b] = words[OFF +: 8];
  end

  always_comb begin
    sel = '0;
    if (32'(idx) < NB) sel = lanes[idx];
  end

endmodule

// File: rtl/debug_ctrl.sv
// Host-driven debug controller: single-step / free-run the pipeline and
// stream a coherent snapshot of NUM_WORDS debug words over the UART.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 2,
  parameter int unsigned LSB_FIRST   = 0,
  parameter int unsigned STEP_SETTLE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data_in,
  input  logic                    rx_done,
  input  logic                    tx_busy,
  input  logic [NUM_WORDS*32-1:0] inWords,
  output logic                    outStep,
  output logic                    outRun,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    busy
);

  localparam int unsigned         NB       = NUM_WORDS * 4;
  localparam int unsigned         IDX_W    = idx_width(NB);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NB - 1);

  state_t                  state;
  logic [7:0]              settle_cnt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        sel_idx;
  logic [NUM_WORDS*32-1:0] snapshot;
  logic [NUM_WORDS*32-1:0] sel_words;
  logic [7:0]              sel_byte;
  logic                    wait_skip;

  // tx_data is registered on entry to SEND, so the selector looks one byte
  // ahead; in LATCH it reads the live words that are being captured.
  always_comb begin
    sel_words = snapshot;
    sel_idx   = idx + IDX_W'(1);
    if (state == ST_LATCH) begin
      sel_words = inWords;
      sel_idx   = '0;
    end
  end

  debug_byte_sel #(
    .NUM_WORDS (NUM_WORDS),
    .LSB_FIRST (LSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_byte_sel (
    .words (sel_words),
    .idx   (sel_idx),
    .sel   (sel_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      snapshot   <= '0;
      wait_skip  <= 1'b0;
      outStep    <= 1'b0;
      outRun     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
    end else begin
      outStep  <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            case (rx_data_in)
              CMD_STEP: begin
                outStep    <= 1'b1;
                busy       <= 1'b1;
                settle_cnt <= '0;
                state      <= ST_SETTLE;
              end
              CMD_CONT: begin
                outRun <= 1'b1;
                state  <= ST_RUN;
              end
              CMD_DUMP: begin
                busy  <= 1'b1;
                state <= ST_LATCH;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (rx_done && rx_data_in == CMD_HALT) begin
            outRun     <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'(STEP_SETTLE)) state <= ST_LATCH;
          else settle_cnt <= settle_cnt + 8'd1;
        end
        ST_LATCH: begin
          snapshot <= inWords;
          idx      <= '0;
          tx_data  <= sel_byte;
          tx_start <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          wait_skip <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // First WAIT cycle is skipped: tx_busy only rises one cycle after tx_start.
          if (wait_skip) begin
            wait_skip <= 1'b0;
          end else if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              idx      <= sel_idx;
              tx_data  <= sel_byte;
              tx_start <= 1'b1;
              state    <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: two instances (MSB-first with settle 4, LSB-first with
// settle 0) share the host stimulus and are checked against a timing model.
module tb_debug_ctrl;
  import debug_pkg::*;

  localparam int unsigned NW = 2;
  localparam int unsigned NB = NW * 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      rx_data_in = '0;
  logic            rx_done = 1'b0;
  logic [NW*32-1:0] in_words = '0;
  logic [1:0]      tx_busy = '0;
  logic [1:0]      out_step, out_run, tx_start, busy;
  logic [7:0]      tx_data [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debug_ctrl #(.NUM_WORDS(NW), .LSB_FIRST(0), .STEP_SETTLE(4)) dut_msb (
    .clk(clk), .reset(reset), .rx_data_in(rx_data_in), .rx_done(rx_done),
    .tx_busy(tx_busy[0]), .inWords(in_words), .outStep(out_step[0]),
    .outRun(out_run[0]), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
    .busy(busy[0])
  );

  debug_ctrl #(.NUM_WORDS(NW), .LSB_FIRST(1), .STEP_SETTLE(0)) dut_lsb (
    .clk(clk), .reset(reset), .rx_data_in(rx_data_in), .rx_done(rx_done),
    .tx_busy(tx_busy[1]), .inWords(in_words), .outStep(out_step[1]),
    .outRun(out_run[1]), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
    .busy(busy[1])
  );

  function automatic int settle_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  // UART tx stand-in: busy rises the cycle after tx_start, holds 1..6 cycles.
  int unsigned busy_left [2];
  bit          pend [2];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        tx_busy[i]   = 1'b1;
        busy_left[i] = $urandom_range(1, 6);
        pend[i]      = 1'b0;
      end else if (busy_left[i] > 0) begin
        busy_left[i]--;
        if (busy_left[i] == 0) tx_busy[i] = 1'b0;
      end
      if (tx_start[i] === 1'b1) pend[i] = 1'b1;
    end
  end

  // Reference model: commands are accepted only while not busy; each accepted
  // dump is a time-stamped schedule (latch cycle, then byte starts gated by tx_busy).
  int         cyc = 0;
  bit         m_on = 1'b0;
  bit         e_run [2], e_busy [2], e_step [2], e_start [2], e_chkdata [2], sending [2];
  logic [7:0] e_data [2];
  int         latch_at [2];
  int         last_start [2];
  logic [7:0] m_bytes [2][NB];
  int         m_ptr [2];

  always @(posedge clk) begin
    cyc++;
    m_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bit was_busy;
      was_busy     = e_busy[i];
      e_step[i]    = 1'b0;
      e_start[i]   = 1'b0;
      e_chkdata[i] = 1'b0;
      if (reset) begin
        e_run[i] = 0; e_busy[i] = 0; sending[i] = 0;
        e_data[i] = '0; e_chkdata[i] = 1'b1; latch_at[i] = -10;
      end else begin
        if (sending[i] && cyc >= last_start[i] + 3 && !tx_busy[i]) begin
          if (m_ptr[i] == NB) begin
            sending[i] = 1'b0;
            e_busy[i]  = 1'b0;
          end else begin
            e_start[i] = 1'b1;
            e_data[i]  = m_bytes[i][m_ptr[i]];
            m_ptr[i]++;
            last_start[i] = cyc;
          end
        end
        if (latch_at[i] >= 0 && cyc == latch_at[i] + 1) begin
          for (int w = 0; w < NW; w++)
            for (int k = 0; k < 4; k++) begin
              int sh;
              sh = (i == 1) ? 8 * k : 24 - 8 * k;
              m_bytes[i][w*4+k] = 8'(in_words >> (w * 32 + sh));
            end
          e_start[i] = 1'b1;
          e_data[i]  = m_bytes[i][0];
          m_ptr[i]   = 1;
          last_start[i] = cyc;
          sending[i] = 1'b1;
          latch_at[i] = -10;
        end
        if (rx_done && !was_busy) begin
          if (rx_data_in == CMD_STEP && !e_run[i]) begin
            e_step[i] = 1'b1; e_busy[i] = 1'b1; latch_at[i] = cyc + 1 + settle_of(i);
          end else if (rx_data_in == CMD_CONT && !e_run[i]) begin
            e_run[i] = 1'b1;
          end else if (rx_data_in == CMD_HALT && e_run[i]) begin
            e_run[i] = 1'b0; e_busy[i] = 1'b1; latch_at[i] = cyc + 1 + settle_of(i);
          end else if (rx_data_in == CMD_DUMP && !e_run[i]) begin
            e_busy[i] = 1'b1; latch_at[i] = cyc;
          end
        end
      end
      if (e_start[i]) e_chkdata[i] = 1'b1;
    end
  end

  logic [7:0] tx_log [2][64];
  int         nlog [2];
  int         step_cnt [2];
  int         run_cnt [2];

  always @(negedge clk) begin
    if (m_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("outStep", i, 32'(out_step[i]), 32'(e_step[i]));
        chk("outRun", i, 32'(out_run[i]), 32'(e_run[i]));
        chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
        chk("tx_start", i, 32'(tx_start[i]), 32'(e_start[i]));
        if (e_chkdata[i]) chk("tx_data", i, 32'(tx_data[i]), 32'(e_data[i]));
        if (tx_start[i] === 1'b1) begin
          if (nlog[i] < 64) tx_log[i][nlog[i]] = tx_data[i];
          nlog[i]++;
        end
        if (out_step[i] === 1'b1) step_cnt[i]++;
        if (out_run[i] === 1'b1) run_cnt[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_in = b;
    rx_done    = 1'b1;
    tick(1);
    rx_done    = 1'b0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      nlog[i] = 0; step_cnt[i] = 0; run_cnt[i] = 0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 2'b00 && k < 3000) begin tick(1); k++; end
    chk(nm, 0, 32'(k < 3000), 32'd1);
  endtask

  task automatic wait_logs(input int n);
    int k;
    k = 0;
    while (!(nlog[0] >= n && nlog[1] >= n) && k < 3000) begin tick(1); k++; end
    chk("log_timeout", 0, 32'(k < 3000), 32'd1);
  endtask

  logic [63:0] exp_msb = 64'h05EB_D7AF_0000_0004;
  logic [63:0] exp_lsb = 64'hAFD7_EB05_0400_0000;

  task automatic check_dump(input string nm);
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_len"}, i, 32'(nlog[i]), NB);
      for (int j = 0; j < NB; j++) begin
        e = (i == 0) ? exp_msb[63-8*j -: 8] : exp_lsb[63-8*j -: 8];
        chk({nm, "_byte"}, i, 32'(tx_log[i][j]), 32'(e));
      end
    end
  endtask

  initial begin
    int n_before [2];
    logic [31:0] r;
    clear_stats();
    tick(3);
    chk("reset_outs", 0, 32'({out_step, out_run, tx_start, busy}), 32'd0);
    chk("reset_txdata", 0, 32'({tx_data[0], tx_data[1]}), 32'd0);
    reset = 1'b0;

    send_byte(8'h41);
    tick(10);
    for (int i = 0; i < 2; i++) begin
      chk("junk_step", i, 32'(step_cnt[i]), 0);
      chk("junk_tx", i, 32'(nlog[i]), 0);
    end

    in_words = {32'h0000_0004, 32'h05EB_D7AF};
    clear_stats();
    send_byte(CMD_STEP);
    wait_idle("step_idle");
    tick(2);
    for (int i = 0; i < 2; i++) chk("step_pulses", i, 32'(step_cnt[i]), 1);
    check_dump("step_dump");

    clear_stats();
    send_byte(CMD_CONT);
    tick(50);
    send_byte(CMD_HALT);
    tick(3);
    send_byte(CMD_STEP);
    wait_idle("halt_idle");
    tick(2);
    for (int i = 0; i < 2; i++) begin
      chk("run_cycles", i, 32'(run_cnt[i]), 51);
      chk("step_dropped", i, 32'(step_cnt[i]), 0);
    end
    check_dump("halt_dump");

    clear_stats();
    send_byte(CMD_DUMP);
    wait_logs(1);
    in_words = '1;
    wait_idle("coh_idle");
    check_dump("coherent");

    in_words = {32'h0000_0004, 32'h05EB_D7AF};
    clear_stats();
    send_byte(CMD_DUMP);
    wait_logs(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_before[0] = nlog[0];
    n_before[1] = nlog[1];
    tick(30);
    for (int i = 0; i < 2; i++) chk("no_tx_after_reset", i, 32'(nlog[i]), 32'(n_before[i]));
    clear_stats();
    send_byte(CMD_DUMP);
    wait_idle("post_reset_idle");
    check_dump("post_reset");

    for (int it = 0; it < 300; it++) begin
      in_words = {$urandom, $urandom};
      r = $urandom_range(0, 99);
      if (r < 20)      send_byte(CMD_STEP);
      else if (r < 40) send_byte(CMD_CONT);
      else if (r < 60) send_byte(CMD_HALT);
      else if (r < 80) send_byte(CMD_DUMP);
      else if (r < 97) send_byte(8'($urandom));
      else begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick($urandom_range(0, 12));
    end
    send_byte(CMD_HALT);
    wait_idle("final_idle");
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout inst0: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debug_ctrl.md
# debug_ctrl

Parametrised debug controller for the pipelined MIPS core, sitting between the UART byte transceiver and the pipeline's step/run enable. It decodes single-byte commands from the host, single-steps or free-runs the pipeline, and streams a coherent snapshot of NUM_WORDS 32-bit debug words (PC, registers, latch contents) back over the UART. It extends the current fixed two-word step-and-dump unit with a configurable word count, byte order, settle delay, and continuous-run/halt and dump-only modes.

## Interface
- NUM_WORDS, 2, number of 32-bit words per dump (1..64).
- LSB_FIRST, 0, 0 = each word sent MSB byte first, 1 = LSB byte first.
- STEP_SETTLE, 4, cycles between the outStep pulse and snapshot latch (0..255).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_data_in  in  8  received byte from UART rx; valid when rx_done = 1.
- rx_done  in  1  one-cycle strobe for a new received byte.
- tx_busy  in  1  UART tx busy; must rise the cycle after tx_start and stay high until the byte is sent.
- inWords  in  NUM_WORDS*32  debug words, word 0 in bits [31:0].
- outStep  out  1  one-cycle pipeline step enable.
- outRun  out  1  continuous pipeline enable.
- tx_data  out  8  byte to transmit; stable while tx_start = 1.
- tx_start  out  1  one-cycle transmit request.
- busy  out  1  high in every state except IDLE and RUN.

## Operation
- Commands (shared package constants): CMD_STEP 0x73 's', CMD_CONT 0x63 'c', CMD_HALT 0x68 'h', CMD_DUMP 0x64 'd'. Any other byte is ignored.
- States: IDLE, RUN, SETTLE, LATCH, SEND, WAIT.
- IDLE: 's' -> outStep = 1 for one cycle, go to SETTLE. 'c' -> RUN. 'd' -> LATCH. 'h' ignored.
- RUN: outRun = 1. 'h' -> outRun drops, go to SETTLE (halt, then dump). All other bytes ignored.
- SETTLE: count STEP_SETTLE cycles, then LATCH. With STEP_SETTLE = 0, SETTLE lasts exactly one cycle.
- LATCH: copy inWords into the snapshot register in one cycle; clear byte index; go to SEND.
- SEND: drive tx_data = snapshot byte[index], pulse tx_start, go to WAIT.
- WAIT: skip the first cycle, then wait for tx_busy = 0. If the index is the last byte (NUM_WORDS*4-1), go to IDLE; otherwise increment the index and go to SEND.
- Byte order:
  - Word w is sent in full before word w+1.
  - LSB_FIRST = 0: bytes [31:24], [23:16], [15:8], [7:0].
  - LSB_FIRST = 1: the reverse order.
- Byte index width is clog2(NUM_WORDS*4), minimum 1. It never wraps past the last byte.
- Any rx_done while busy = 1 is dropped, including 's', 'c' and 'h'. There is no queueing.
- Reset, synchronous and at any state including mid-dump:
  - State goes to IDLE and the index clears.
  - outStep, outRun, tx_start, busy and tx_data all go to 0.
  - The snapshot clears to 0.

## Timing
- rx_done in IDLE with 's' at cycle N: outStep = 1 at N+1 only, and busy = 1 from N+1.
- The snapshot is latched at cycle N+2+STEP_SETTLE.
- The first tx_start is at N+3+STEP_SETTLE.
- 'c' at cycle N: outRun = 1 from N+1. 'h' at cycle M: outRun = 0 from M+1.
- tx_start is never asserted while tx_busy = 1. Minimum spacing between tx_start pulses is 3 cycles.
- Snapshot coherency: changes to inWords after LATCH never appear in the transmitted bytes.
- busy falls the cycle after the final byte's tx_busy falls.

## Structure
- Package debug_pkg holds:
  - The four command constants.
  - The state enum.
  - A function computing the byte-index width.
- One sub-module, debug_byte_sel: combinational selection of snapshot byte[index] honouring LSB_FIRST.
- The FSM, settle counter, and snapshot register stay in debug_ctrl.
- The UART rx/tx cores are instantiated outside this block.

## Test plan
- Reset: hold reset 3 cycles. Every output is 0 and busy = 0; after release, rx_done with 0x41 produces no output activity.
- Step/dump: NUM_WORDS = 2, LSB_FIRST = 0, inWords = {32'h0000_0004, 32'h05EB_D7AF}, send 0x73.
  - Exactly one outStep pulse.
  - tx bytes in order: 05 EB D7 AF 00 00 00 04.
  - busy drops after the 8th byte.
- Byte order: same stimulus with LSB_FIRST = 1 -> AF D7 EB 05 04 00 00 00.
- Run/halt: send 0x63, wait 50 cycles, send 0x68.
  - outRun is high for exactly the cycles between the two strobes, plus one.
  - Then a full dump follows.
  - A 0x73 sent during the dump produces no outStep.
- Coherency: send 0x64, then change inWords to all-ones after the first tx_start. The original values are transmitted.
- Mid-dump reset: assert reset after the 3rd byte.
  - tx_start never pulses again.
  - Back in IDLE; a subsequent 0x64 yields a complete 8-byte dump.
